// File: rtl/pulse_gen_pkg.sv
// ============================================================================
//  Module  : pulse_gen_pkg
//  Brief   : Shared state encoding and mode constants for the multi-channel
//            pulse generator.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_gen_pkg;

  // Two-state channel FSM
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-channel mode input encoding
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pulse_channel.sv
// ============================================================================
//  Module  : pulse_channel
//  Brief   : One pulse/PWM channel: IDLE/RUN FSM plus period counter with
//            live (unshadowed) period and width compares.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         mode,
  input  logic         start,
  input  logic         clr,
  input  logic [N-1:0] ticks,
  input  logic [N-1:0] width,
  output logic         out,
  output logic         last,
  output logic         busy
);

  state_t       state;
  logic [N-1:0] count;

  // Outputs decode straight from registered state; >= on the period compare
  // lets a shrinking ticks value end the period instead of wrapping.
  assign busy = (state == RUN);
  assign out  = busy & (count < width);
  assign last = busy & (count >= ticks);

  // Channel FSM and counter, priority: enable, clear, start-up, period end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else if (!ena) begin
      state <= IDLE;
      count <= '0;
    end else if (clr) begin
      count <= '0;
      state <= (mode == MODE_ONESHOT) ? IDLE : RUN;
    end else if (state == IDLE) begin
      if ((mode == MODE_PERIODIC) || start) begin
        state <= RUN;
        count <= '0;
      end
    end else if (last) begin
      count <= '0;
      state <= (mode == MODE_ONESHOT) ? IDLE : RUN;
    end else begin
      count <= count + N'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulse_generator_multi.sv
// ============================================================================
//  Module  : pulse_generator_multi
//  Brief   : CHANNELS independent programmable pulse generators sharing a
//            clock and reset; ticks/width buses are packed N bits per channel.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_generator_multi
  import pulse_gen_pkg::*;
#(
  parameter int N        = 8,
  parameter int CHANNELS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   ena,
  input  logic [CHANNELS-1:0]   mode,
  input  logic [CHANNELS-1:0]   start,
  input  logic [CHANNELS-1:0]   clr,
  input  logic [CHANNELS*N-1:0] ticks,
  input  logic [CHANNELS*N-1:0] width,
  output logic [CHANNELS-1:0]   out,
  output logic [CHANNELS-1:0]   last,
  output logic [CHANNELS-1:0]   busy
);

  // One fully independent channel per bit of the control vectors
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_channel #(
      .N (N)
    ) u_channel (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena[i]),
      .mode  (mode[i]),
      .start (start[i]),
      .clr   (clr[i]),
      .ticks (ticks[i*N +: N]),
      .width (width[i*N +: N]),
      .out   (out[i]),
      .last  (last[i]),
      .busy  (busy[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pulse_generator_multi.sv
// ============================================================================
//  Module  : tb_pulse_generator_multi
//  Brief   : Self-checking bench for pulse_generator_multi with a behavioural
//            per-channel reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_generator_multi;

  localparam int N  = 8;
  localparam int CH = 4;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   ena, mode, start, clr;
  logic [CH*N-1:0] ticks, width;
  logic [CH-1:0]   out, last, busy;

  int errors = 0;
  int checks = 0;

  // Reference model: running flag and position within the period
  bit m_run [CH];
  int m_cnt [CH];

  pulse_generator_multi #(.N(N), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .mode  (mode),
    .start (start),
    .clr   (clr),
    .ticks (ticks),
    .width (width),
    .out   (out),
    .last  (last),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get_ticks(int ch);
    return int'(ticks[ch*N +: N]);
  endfunction

  function automatic int get_width(int ch);
    return int'(width[ch*N +: N]);
  endfunction

  task automatic set_tw(int ch, int t, int w);
    ticks[ch*N +: N] = N'(t);
    width[ch*N +: N] = N'(w);
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 1'b0;
      m_cnt[i] = 0;
    end
  endtask

  // Apply the channel rules for one clock edge using the inputs at the edge
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (!ena[i]) begin
          m_run[i] = 1'b0;
          m_cnt[i] = 0;
        end else if (clr[i]) begin
          m_cnt[i] = 0;
          m_run[i] = !mode[i];
        end else if (!m_run[i]) begin
          if (!mode[i] || start[i]) begin
            m_run[i] = 1'b1;
            m_cnt[i] = 0;
          end
        end else if (m_cnt[i] >= get_ticks(i)) begin
          m_cnt[i] = 0;
          m_run[i] = !mode[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic check_model(string tag);
    logic [CH-1:0] e_out, e_last, e_busy;
    for (int i = 0; i < CH; i++) begin
      e_busy[i] = m_run[i];
      e_out[i]  = m_run[i] && (m_cnt[i] < get_width(i));
      e_last[i] = m_run[i] && (m_cnt[i] >= get_ticks(i));
    end
    checks++;
    assert (out === e_out) else begin
      errors++;
      $error("FAIL %s out got=%b exp=%b", tag, out, e_out);
    end
    checks++;
    assert (last === e_last) else begin
      errors++;
      $error("FAIL %s last got=%b exp=%b", tag, last, e_last);
    end
    checks++;
    assert (busy === e_busy) else begin
      errors++;
      $error("FAIL %s busy got=%b exp=%b", tag, busy, e_busy);
    end
  endtask

  task automatic check_bit(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // One clock: advance the model at the edge, check 1 time unit later
  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = '0;
    mode  = '0;
    start = '0;
    clr   = '0;
    ticks = '0;
    width = '0;
    model_reset();

    // Reset state
    #2;
    check_model("reset");
    repeat (3) tick("reset_hold");
    rst_n = 1'b1;
    tick("reset_release");

    // Periodic ch0: ticks=4 width=2, ena raised after edge 0
    set_tw(0, 4, 2);
    tick("per_edge0");
    ena[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick("periodic");
      check_bit($sformatf("per_out_c%0d", c),  out[0],  ((c - 1) % 5) < 2);
      check_bit($sformatf("per_last_c%0d", c), last[0], ((c - 1) % 5) == 4);
      check_bit($sformatf("per_busy_c%0d", c), busy[0], 1'b1);
    end
    ena[0] = 1'b0;
    tick("per_off");

    // One-shot ch1: ticks=3 width=1; second start at cycle 2 is ignored
    set_tw(1, 3, 1);
    mode[1] = 1'b1;
    ena[1]  = 1'b1;
    tick("os_arm");
    tick("os_edge0");
    start[1] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick("oneshot");
      start[1] = (c == 2);
      check_bit($sformatf("os_busy_c%0d", c), busy[1], (c >= 1) && (c <= 4));
      check_bit($sformatf("os_out_c%0d", c),  out[1],  c == 1);
      check_bit($sformatf("os_last_c%0d", c), last[1], c == 4);
    end

    // clr together with start in one-shot keeps channel idle
    clr[1]   = 1'b1;
    start[1] = 1'b1;
    tick("os_clr_start");
    check_bit("os_clr_start_busy", busy[1], 1'b0);
    clr[1]   = 1'b0;
    start[1] = 1'b0;
    tick("os_clr_start_after");
    check_bit("os_clr_start_busy2", busy[1], 1'b0);
    ena[1] = 1'b0;

    // Boundaries: ticks=0 on ch2, width=0 on ch3, width>period on ch0
    set_tw(2, 0, 1);
    set_tw(3, 5, 0);
    set_tw(0, 4, 9);
    mode = '0;
    ena  = 4'b1101;
    repeat (12) tick("boundary");
    check_bit("bnd_last_t0", last[2], 1'b1);
    check_bit("bnd_out_w0",  out[3],  1'b0);
    check_bit("bnd_out_sat", out[0],  1'b1);
    ena = '0;
    tick("bnd_off");

    // Live ticks shrink: ch0 ticks 10 -> 2 once count reaches 6
    set_tw(0, 10, 3);
    ena[0] = 1'b1;
    tick("live_start");
    repeat (6) tick("live_run");
    set_tw(0, 2, 3);
    repeat (10) tick("live_shrunk");

    // Phase clear at count 3 on ch0 (ticks=8)
    set_tw(0, 8, 4);
    clr[0] = 1'b1;
    tick("clr_sync");
    clr[0] = 1'b0;
    repeat (3) tick("clr_run");
    clr[0] = 1'b1;
    tick("clr_pulse");
    clr[0] = 1'b0;
    repeat (6) tick("clr_after");

    // Multi-channel periods 2,3,4,5, then disable ch2
    for (int i = 0; i < CH; i++) set_tw(i, i + 1, 1);
    ena  = '0;
    mode = '0;
    tick("multi_idle");
    ena = '1;
    repeat (20) tick("multi");
    ena[2] = 1'b0;
    repeat (20) tick("multi_ch2_off");

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) begin
        ena[i]   = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 15) == 0) mode[i] = ~mode[i];
        start[i] = ($urandom_range(0, 3) == 0);
        clr[i]   = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 7) == 0)
          set_tw(i, $urandom_range(0, 12), $urandom_range(0, 14));
      end
      tick("random");
    end

    // Asynchronous reset while ch0 is near the end of its period
    ena   = 4'b0001;
    mode  = '0;
    start = '0;
    clr   = '0;
    set_tw(0, 5, 6);
    tick("arst_start");
    repeat (4) tick("arst_run");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("arst_immediate");
    check_bit("arst_busy0", busy[0], 1'b0);
    repeat (2) tick("arst_hold");
    rst_n = 1'b1;
    tick("arst_release");
    check_bit("arst_restart_busy", busy[0], 1'b1);
    check_bit("arst_restart_last", last[0], 1'b0);
    repeat (8) tick("arst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
